// File: rtl/jk_pkg.sv
// Shared types for the JK latch driver: command encoding, FSM states and
// the phase-length helper used to clamp zero-length windows to one cycle.
package jk_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_RST = 2'b01,
    CMD_SET = 2'b10,
    CMD_TGL = 2'b11
  } jk_cmd_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } jk_state_e;

  localparam int unsigned JK_CNT_W_DEF = 4;

  // A window of 0 cycles would collapse a phase, so it is stretched to 1.
  function automatic int unsigned eff_cyc(input int unsigned cyc);
    return (cyc == 0) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/jk_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset, used to bring the
// latch q output into the clk domain.
module jk_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/jk_latch_driver.sv
// Sequences j/k/e of one enabled JK latch from set/reset/toggle/nop commands.
// Optional macro JKDRV_VERIFY_EN adds a post-hold read-back check driving err.
module jk_latch_driver
  import jk_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned CNT_W     = JK_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       q_fb,
  output logic       j,
  output logic       k,
  output logic       e,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Counters load length-1 and the phase ends when they reach zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(eff_cyc(SETUP_CYC) - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(eff_cyc(PULSE_CYC) - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(eff_cyc(HOLD_CYC) - 1);

  if (SETUP_CYC > (2 ** CNT_W) - 1 || PULSE_CYC > (2 ** CNT_W) - 1 ||
      HOLD_CYC > (2 ** CNT_W) - 1) begin : g_cnt_range_chk
    $error("jk_latch_driver: a *_CYC value exceeds the CNT_W counter range");
  end

  jk_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  jk_cmd_e          op_q, op_d;
  logic             q_s;
  logic             accept;
  logic             drive_jk;

  logic cmd_ready_q, cmd_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic j_q, j_d;
  logic k_q, k_d;
  logic e_q, e_d;

  jk_sync2 u_q_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (q_fb),
    .q_o   (q_s)
  );

  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (jk_cmd_e'(cmd))
            CMD_NOP: begin
              op_d    = CMD_NOP;
              state_d = DONE;
            end
            CMD_TGL: begin
              op_d    = q_s ? CMD_RST : CMD_SET;
              state_d = SETUP;
              cnt_d   = SETUP_LD;
            end
            default: begin
              op_d    = jk_cmd_e'(cmd);
              state_d = SETUP;
              cnt_d   = SETUP_LD;
            end
          endcase
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    drive_jk    = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    j_d         = drive_jk && (op_d == CMD_SET);
    k_d         = drive_jk && (op_d == CMD_RST);
    e_d         = (state_d == PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= CMD_NOP;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      j_q         <= j_d;
      k_q         <= k_d;
      e_q         <= e_d;
    end
  end

`ifdef JKDRV_VERIFY_EN
  if (HOLD_CYC < 3) begin : g_hold_chk
    $error("jk_latch_driver: read-back check needs HOLD_CYC >= 3");
  end

  logic err_q, err_d;

  // Sampled on the HOLD->DONE edge, i.e. the last HOLD cycle; nop never gets here.
  always_comb begin
    err_d = (state_q == HOLD) && (cnt_q == '0) && (q_s != (op_q == CMD_SET));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign j         = j_q;
  assign k         = k_q;
  assign e         = e_q;

  a_jk_excl : assert property (@(posedge clk) disable iff (!rst_n) !(j && k));
  a_jk_on_e_edge : assert property (@(posedge clk) disable iff (!rst_n)
    (e != $past(e)) |-> (j == $past(j) && k == $past(k)));

endmodule

// File: tb/tb_jk_latch_driver.sv
// Directed bench for jk_latch_driver with a behavioural enabled JK latch fed
// back on q_fb; builds with or without JKDRV_VERIFY_EN.
module tb_jk_latch_driver;
  import jk_pkg::*;

  localparam int unsigned S_CYC = 1;
  localparam int unsigned P_CYC = 2;
`ifdef JKDRV_VERIFY_EN
  localparam int unsigned H_CYC  = 3;
  localparam bit          VERIFY = 1'b1;
`else
  localparam int unsigned H_CYC  = 1;
  localparam bit          VERIFY = 1'b0;
`endif
  localparam int unsigned T_CYC = S_CYC + P_CYC + H_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_ready, j, k, e, busy, done, err;
  logic       q_fb;
  logic       q_model = 1'b0;
  bit         stuck = 1'b0;

  int errors = 0;
  int checks = 0;
  logic prev_j, prev_k, prev_e;
  bit   prev_ok = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  jk_latch_driver #(
    .SETUP_CYC (S_CYC),
    .PULSE_CYC (P_CYC),
    .HOLD_CYC  (H_CYC),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .e         (e),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // enabled JK latch model; stuck forces a dead cell
  always @* begin
    if (stuck) q_model = 1'b0;
    else if (e) begin
      if (j && !k) q_model = 1'b1;
      else if (!j && k) q_model = 1'b0;
    end
  end
  assign q_fb = q_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected {cmd_ready,busy,done,j,k,e} for cycle c after an accept at cycle 0
  task automatic check_cycle(input int c, input logic [1:0] op, input bit exp_err);
    logic [5:0] exp_v;
    logic       is_set, is_rst, exp_e;
    is_set = (op == CMD_SET);
    is_rst = (op == CMD_RST);
    exp_e  = 1'b0;
    if (op == CMD_NOP) begin
      exp_v = (c == 1) ? 6'b011000 : 6'b100000;
    end else if (c <= int'(T_CYC)) begin
      exp_e = (c > int'(S_CYC)) && (c <= int'(S_CYC + P_CYC));
      exp_v = {1'b0, 1'b1, 1'b0, is_set, is_rst, exp_e};
    end else if (c == int'(T_CYC) + 1) begin
      exp_v = 6'b011000;
    end else begin
      exp_v = 6'b100000;
    end
    check($sformatf("c%0d_op%0d_outs", c, op), {cmd_ready, busy, done, j, k, e}, exp_v);
    check($sformatf("c%0d_err", c), err,
          (op != CMD_NOP && c == int'(T_CYC) + 1) ? exp_err : 1'b0);
    check("jk_excl", j & k, 0);
    if (prev_ok && (e !== prev_e))
      check("jk_stable_on_e_edge", {j, k}, {prev_j, prev_k});
    prev_j  = j;
    prev_k  = k;
    prev_e  = e;
    prev_ok = 1'b1;
  endtask

  // driver: call from an IDLE cycle; returns in the following IDLE cycle
  task automatic run_cmd(input logic [1:0] c_in, input logic [1:0] op,
                         input bit exp_err, input logic exp_q);
    int last;
    last = (op == CMD_NOP) ? 2 : int'(T_CYC) + 2;
    check("c0_ready", cmd_ready, 1'b1);
    prev_ok   = 1'b0;
    cmd_valid = 1'b1;
    cmd       = c_in;
    for (int c = 1; c <= last; c++) begin
      tick();
      cmd_valid = 1'b0;
      cmd       = 2'($urandom_range(0, 3));
      check_cycle(c, op, exp_err);
    end
    check("latch_q", q_model, exp_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for 3 cycles
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", {cmd_ready, busy, done, j, k, e, err}, 7'b0);
    end
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", cmd_ready, 1'b1);

    run_cmd(CMD_SET, CMD_SET, 1'b0, 1'b1);
    run_cmd(CMD_TGL, CMD_RST, 1'b0, 1'b0);
    run_cmd(CMD_TGL, CMD_SET, 1'b0, 1'b1);
    run_cmd(CMD_NOP, CMD_NOP, 1'b0, 1'b1);

    // back-to-back with valid held high; cmd is noise while ready is low
    prev_ok   = 1'b0;
    cmd_valid = 1'b1;
    cmd       = CMD_RST;
    for (int n = 0; n < 4; n++) begin
      logic [1:0] op;
      op = n[0] ? CMD_SET : CMD_RST;
      check($sformatf("b2b%0d_accept_ready", n), cmd_ready, 1'b1);
      for (int c = 1; c <= int'(T_CYC) + 1; c++) begin
        tick();
        if (c == int'(T_CYC) + 1) begin
          cmd       = n[0] ? CMD_RST : CMD_SET;
          cmd_valid = (n != 3);
        end else begin
          cmd = 2'($urandom_range(0, 3));
        end
        check_cycle(c, op, 1'b0);
      end
      check($sformatf("b2b%0d_q", n), q_model, n[0] ? 1'b1 : 1'b0);
      tick();
    end
    check_cycle(int'(T_CYC) + 2, CMD_SET, 1'b0);

    // reset in the second pulse cycle
    cmd_valid = 1'b1;
    cmd       = CMD_SET;
    for (int c = 1; c <= int'(S_CYC) + 2; c++) begin
      tick();
      cmd_valid = 1'b0;
    end
    check("pre_rst_e", e, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("midrst_outs", {e, j, k, busy, done, cmd_ready}, 6'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {cmd_ready, busy, done, e}, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_quiet", {cmd_ready, busy, done, e}, 4'b1000);
    end

    // dead latch: read-back flags only when the check is built in
    stuck = 1'b1;
    run_cmd(CMD_SET, CMD_SET, VERIFY, 1'b0);
    stuck = 1'b0;
    run_cmd(CMD_SET, CMD_SET, 1'b0, 1'b1);
    run_cmd(CMD_RST, CMD_RST, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
